rtype_exec_ctrl: RTL

//  Multi-cycle R-type (RV32I OP, opcode 7'b0110011) execution controller sitting around the 32x32 register file.

---
 rtl/rtype_pkg.sv | 60 ++++++
 rtl/rtype_alu.sv | 34 +++
 rtl/rtype_exec_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/rtype_pkg.sv
// Shared constants, enums and decode helper for the R-type execution controller.
package rtype_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ILL
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  // Maps an instruction word to an ALU operation; anything not a listed R-type is ALU_ILL.
  function automatic alu_op_e decode_op(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    logic [6:0] op;
    alu_op_e    res;
    f7  = w[31:25];
    f3  = w[14:12];
    op  = w[6:0];
    res = ALU_ILL;
    if (op == OPC_OP) begin
      if (f7 == F7_BASE) begin
        case (f3)
          F3_ADD:  res = ALU_ADD;
          F3_SLL:  res = ALU_SLL;
          F3_SLT:  res = ALU_SLT;
          F3_SLTU: res = ALU_SLTU;
          F3_XOR:  res = ALU_XOR;
          F3_SR:   res = ALU_SRL;
          F3_OR:   res = ALU_OR;
          default: res = ALU_AND;
        endcase
      end else if (f7 == F7_ALT) begin
        case (f3)
          F3_ADD:  res = ALU_SUB;
          F3_SR:   res = ALU_SRA;
          default: res = ALU_ILL;
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational R-type ALU; unsupported ops yield zero and flag illegal.
module rtype_alu
  import rtype_pkg::*;
(
  input  alu_op_e          alu_op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y,
  output logic             illegal
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Evaluate the selected operation; results wrap modulo 2^XLEN.
  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (alu_op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rtype_exec_ctrl.sv
// Four-phase R-type controller: capture, read register file, execute, write back.
//
// state | meaning
// IDLE  | waiting for an instruction, instr_ready high
// READ  | register file read strobe for rs1/rs2
// EXEC  | operands present, result and illegal captured
// WB    | done pulse, write strobe for legal ops with rd != x0
module rtype_exec_ctrl
  import rtype_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [XLEN-1:0]  instr,
  output logic             rf_rd_en,
  output logic [AW-1:0]    rf_rd_addr1,
  output logic [AW-1:0]    rf_rd_addr2,
  input  logic [XLEN-1:0]  rf_rd_data1,
  input  logic [XLEN-1:0]  rf_rd_data2,
  output logic             rf_wr_en,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [XLEN-1:0]  rf_wr_data,
  output logic             done,
  output logic             illegal,
  output logic [XLEN-1:0]  result
);

  state_e          state;
  logic [XLEN-1:0] instr_q;
  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_y;
  logic            alu_ill;

  // Addresses come straight from the captured word, so they stay stable for the whole instruction.
  assign rf_rd_addr1 = instr_q[19:15];
  assign rf_rd_addr2 = instr_q[24:20];
  assign rf_wr_addr  = instr_q[11:7];
  assign rf_wr_data  = result;
  assign alu_op      = decode_op(instr_q);

  rtype_alu u_alu (
    .alu_op  (alu_op),
    .a       (rf_rd_data1),
    .b       (rf_rd_data2),
    .y       (alu_y),
    .illegal (alu_ill)
  );

  // Sequencer with registered strobes; a reset at any point drops the in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_q     <= '0;
      instr_ready <= 1'b1;
      rf_rd_en    <= 1'b0;
      rf_wr_en    <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q     <= instr;
            instr_ready <= 1'b0;
            rf_rd_en    <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          rf_rd_en <= 1'b0;
          state    <= EXEC;
        end
        EXEC: begin
          result   <= alu_y;
          illegal  <= alu_ill;
          done     <= 1'b1;
          rf_wr_en <= !alu_ill && (instr_q[11:7] != '0);
          state    <= WB;
        end
        WB: begin
          done        <= 1'b0;
          rf_wr_en    <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
